// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter.
//   owner_e               : who owns the access issued in the previous cycle
//   STARVE_LIMIT_DEFAULT  : default cap on consecutive data grants while a
//                           fetch is waiting
package sram_arbiter_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates a fetch port (inst_*) and a load/store port (data_*) onto one
// single-port SRAM with one-cycle read latency.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/wen/addr/wdata       fetch request
//   inst_cancel                   pipeline flush: kills the fetch response due
//                                 this cycle and blocks a fetch grant this cycle
//   inst_addr_ok/data_ok/rdata    fetch accept / response / read data
//   data_req/wen/addr/wdata       load/store request
//   data_addr_ok/data_ok/rdata    load/store accept / response / read data
//   mem_en/wen/addr/wdata         SRAM request side
//   mem_rdata                     SRAM read data, valid one cycle after mem_en
//
// Handshake: a request transfers in the cycle where req=1 and addr_ok=1.
// addr_ok is combinational from req and registered state, so a requester
// that drops req before seeing addr_ok leaves no trace. Every accepted
// request (read or write) gets exactly one data_ok one cycle later, unless
// reset intervenes or, for fetches, inst_cancel is high in that cycle.
//
// Data normally wins; after STARVE_LIMIT consecutive data grants with a
// fetch pending, the fetch is granted next.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  owner_e        owner;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          inst_grant;
  logic          data_grant;

  assign starved = (starve_cnt == LIMIT);

  // A cancelled fetch is never granted; data may use the slot instead.
  assign inst_grant = !rst && inst_req && !inst_cancel && (!data_req || starved);
  assign data_grant = !rst && data_req && !inst_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWNER_NONE;
      starve_cnt <= '0;
    end else begin
      if (inst_grant)      owner <= OWNER_INST;
      else if (data_grant) owner <= OWNER_DATA;
      else                 owner <= OWNER_NONE;

      if (inst_grant || !inst_req)    starve_cnt <= '0;
      else if (data_grant && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (inst_grant) begin
      mem_en    = 1'b1;
      mem_wen   = inst_wen;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else if (data_grant) begin
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = data_grant;

  // Reset gating drops any response still in flight when rst rises.
  assign inst_data_ok = !rst && (owner == OWNER_INST) && !inst_cancel;
  assign data_data_ok = !rst && (owner == OWNER_DATA);

  assign inst_rdata = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata = data_data_ok ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wen     (inst_wen),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge, where inputs are changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sample mid-cycle, well away from the active edge
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic exp_d [10];
  logic prev_inst;

  initial begin
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset with requests active: everything must stay quiet
    rst = 1'b1;
    inst_req = 1'b1; inst_wen = 4'd0; inst_addr = 32'h0000_0010; inst_wdata = 32'd0;
    inst_cancel = 1'b0;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h0000_0020; data_wdata = 32'h1111_1111;
    mem_rdata = 32'hA5A5_A5A5;
    tick(); tick();
    settle();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wen", {28'd0, mem_wen}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);

    // release reset while idle
    tick();
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    settle();
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("idle_data_data_ok", {31'd0, data_data_ok}, 32'd0);

    // lone fetch read
    tick();
    inst_req = 1'b1; inst_wen = 4'd0; inst_addr = 32'hBFC0_0000;
    settle();
    chk("fetch_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("fetch_mem_en", {31'd0, mem_en}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("fetch_mem_wen", {28'd0, mem_wen}, 32'd0);
    tick();
    inst_req = 1'b0; mem_rdata = 32'h3C08_0001;
    settle();
    chk("fetch_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h3C08_0001);
    chk("fetch_no_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("fetch_data_rdata_zero", data_rdata, 32'd0);
    chk("fetch_idle_mem_en", {31'd0, mem_en}, 32'd0);

    // store
    tick();
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    settle();
    chk("store_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("store_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("store_mem_wen", {28'd0, mem_wen}, 32'hF);
    chk("store_mem_addr", mem_addr, 32'h8000_1000);
    chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    data_req = 1'b0; mem_rdata = 32'h1234_5678;
    settle();
    chk("store_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("store_data_rdata", data_rdata, 32'h1234_5678);
    chk("store_inst_rdata_zero", inst_rdata, 32'd0);

    // both held continuously: D,D,D,D,I,D,D,D,D,I
    tick();
    settle();
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h0000_0200;
    prev_inst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("starve_d_ok_%0d", i), {31'd0, data_addr_ok}, {31'd0, exp_d[i]});
      chk($sformatf("starve_i_ok_%0d", i), {31'd0, inst_addr_ok}, {31'd0, !exp_d[i]});
      chk($sformatf("starve_addr_%0d", i), mem_addr, exp_d[i] ? 32'h0000_0200 : 32'h0000_0100);
      if (i > 0)
        chk($sformatf("starve_resp_%0d", i), {31'd0, inst_data_ok}, {31'd0, prev_inst});
      prev_inst = !exp_d[i];
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0;
    settle();
    chk("starve_last_inst_resp", {31'd0, inst_data_ok}, 32'd1);
    chk("starve_last_data_resp", {31'd0, data_data_ok}, 32'd0);

    // fetch granted, then flushed while a load goes through
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0300;
    settle();
    chk("cancel_fetch_grant", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0; inst_cancel = 1'b1;
    data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h0000_0400;
    mem_rdata = 32'hCAFE_0001;
    settle();
    chk("cancel_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("cancel_inst_rdata", inst_rdata, 32'd0);
    chk("cancel_data_grant", {31'd0, data_addr_ok}, 32'd1);
    chk("cancel_mem_addr", mem_addr, 32'h0000_0400);
    tick();
    inst_cancel = 1'b0; data_req = 1'b0; mem_rdata = 32'hCAFE_0002;
    settle();
    chk("cancel_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("cancel_data_rdata", data_rdata, 32'hCAFE_0002);
    chk("cancel_no_inst_ok", {31'd0, inst_data_ok}, 32'd0);

    // cancel blocks a same-cycle fetch grant
    tick();
    inst_req = 1'b1; inst_cancel = 1'b1;
    settle();
    chk("cancel_block_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("cancel_block_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    inst_req = 1'b0; inst_cancel = 1'b0;
    settle();
    chk("cancel_block_no_resp", {31'd0, inst_data_ok}, 32'd0);

    // reset with a load response outstanding
    tick();
    data_req = 1'b1; data_addr = 32'h0000_0500;
    settle();
    chk("rstmid_grant", {31'd0, data_addr_ok}, 32'd1);
    tick();
    rst = 1'b1; data_req = 1'b0; inst_req = 1'b1;
    settle();
    chk("rstmid_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("rstmid_data_rdata", data_rdata, 32'd0);
    chk("rstmid_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    rst = 1'b0; inst_req = 1'b0;
    settle();
    chk("rstrel_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("rstrel_inst_ok", {31'd0, inst_data_ok}, 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while inst_req is pending.
REQ-003 The block SHALL have these ports, clock and reset first:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  inst_req  in  1  fetch request valid
  inst_wen  in  4  fetch byte write enables (normally 0)
  inst_addr  in  32  fetch address
  inst_wdata  in  32  fetch write data
  inst_cancel  in  1  drop the outstanding fetch response (pipeline flush)
  inst_addr_ok  out  1  fetch request accepted this cycle
  inst_data_ok  out  1  fetch response valid
  inst_rdata  out  32  fetch read data
  data_req  in  1  load/store request valid
  data_wen  in  4  load/store byte write enables
  data_addr  in  32  load/store address
  data_wdata  in  32  store data
  data_addr_ok  out  1  load/store request accepted this cycle
  data_data_ok  out  1  load/store response valid
  data_rdata  out  32  load data
  mem_en  out  1  shared single-port SRAM enable
  mem_wen  out  4  SRAM byte write enables
  mem_addr  out  32  SRAM address
  mem_wdata  out  32  SRAM write data
  mem_rdata  in  32  SRAM read data, valid one cycle after mem_en

Function
REQ-004 The block SHALL grant at most one requester per cycle; the grant SHALL be combinational from the req inputs and the registered state.
REQ-005 The block SHALL grant data over inst when both are requested, unless the starvation counter equals STARVE_LIMIT, in which case inst SHALL be granted.
REQ-006 The starvation counter SHALL increment on each data grant while inst_req=1, SHALL clear on any inst grant or whenever inst_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-007 In a granted cycle the block SHALL set mem_en=1, drive mem_wen, mem_addr and mem_wdata from the granted port, and pulse that port's addr_ok; otherwise mem_en=0 and mem_wen=0.
REQ-008 The block SHALL register the owner (NONE, INST or DATA) of each grant and assert that owner's data_ok exactly one cycle after the grant, for reads and writes alike.
REQ-009 inst_rdata and data_rdata SHALL pass mem_rdata through while the matching data_ok=1 and SHALL be 0 otherwise.
REQ-010 Back-to-back grants SHALL be allowed, giving throughput of one access per cycle; the owner register SHALL update every cycle.
REQ-011 inst_cancel=1 SHALL suppress inst_data_ok for an INST owner registered in the previous cycle, and SHALL suppress a same-cycle inst grant (inst_addr_ok=0).
REQ-012 inst_cancel SHALL have no effect on data grants or data responses.
REQ-013 A requester whose req drops before addr_ok SHALL receive no response, and no state change SHALL result.

Reset
REQ-014 While rst=1, all outputs SHALL be 0, the owner SHALL be NONE, and the starvation counter SHALL be 0.
REQ-015 Asserting rst with a response outstanding SHALL drop that response: no data_ok SHALL assert in the cycle after rst deasserts.

Structure
REQ-016 The owner encoding (NONE=0, INST=1, DATA=2) and the default STARVE_LIMIT SHALL reside in the shared defines header.
REQ-017 The block SHALL be a single module with no sub-modules, containing the owner register, the starvation counter and the grant logic.

Verification
REQ-018 inst_req alone at addr 0xBFC00000, mem_rdata=0x3C080001 -> inst_addr_ok=1 at cycle t, inst_data_ok=1 and inst_rdata=0x3C080001 at t+1.
REQ-019 inst_req and data_req held continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-020 data store wen=0xF, addr 0x80001000, wdata 0xDEADBEEF -> mem_wen=0xF and mem_wdata=0xDEADBEEF at t, data_data_ok=1 at t+1.
REQ-021 inst grant at t and inst_cancel=1 at t+1 -> inst_data_ok=0 at t+1; a data grant at t+1 still completes at t+2.
REQ-022 rst asserted at t+1 after a grant at t -> all outputs 0, and no data_ok after rst releases.
